windowed_regfile_4w: RTL and testbench
======================================

WINDOWED_REGFILE_4W -- requirements
Module: windowed_regfile_4w

Interface
REQ-001 The block SHALL have these parameters: none (4 windows, 32-bit data and 72 physical registers are fixed).
REQ-002 Clk  input  1  rising-edge clock for all register writes.
REQ-003 Rst  input  1  reset, asynchronous and active-high.
REQ-004 RFE  input  1  register-file write enable, active-high.
REQ-005 A  input  5  write-port logical register number.
REQ-006 B  input  5  read-port-B logical register number.
REQ-007 C  input  5  read-port-C logical register number.
REQ-008 CWP  input  5  current window pointer; only CWP[1:0] is used, CWP[4:2] SHALL be ignored.
REQ-009 data  input  32  write data.
REQ-010 r_b  output  32  read data for logical register B.
REQ-011 r_c  output  32  read data for logical register C.

Function
REQ-012 Storage SHALL be 72 physical 32-bit registers, P0..P71.
REQ-013 Mapping SHALL apply to logical r (0-31) with w = CWP[1:0]:
- r 0-7 (globals) -> P r, independent of w.
- r 8-31 -> P(8 + ((16*w + r - 8) mod 64)).
REQ-014 The mapping SHALL give these window overlaps:
- ins r24-31 of window w = outs r8-15 of window w+1 (mod 4).
- window 3 ins r24-31 = P8-15, which are window 0 outs.
- locals r16-23 of window w = P(16+16w)..P(23+16w), private to that window.
REQ-015 Write: on rising Clk with RFE=1 and Rst=0, data SHALL be stored to the physical register mapped from A under the current CWP[1:0]; no other register changes.
REQ-016 RFE=0 SHALL leave all registers unchanged.
REQ-017 Logical r0 (P0) SHALL read as 0 at all times; writes to A=0 SHALL be discarded.
REQ-018 Reads SHALL be combinational (zero latency): r_b = P(map(B,CWP)), r_c = P(map(C,CWP)).
- Outputs SHALL update in the same cycle when B, C, CWP or the register contents change.
REQ-019 Read-during-write: a read of the register being written SHALL return the old value before the clock edge and the new value after it; there is no bypass.
REQ-020 B and C SHALL be allowed to be equal; both outputs then carry the same value.
REQ-021 A change of CWP SHALL take effect immediately for reads and for the next write edge; register contents SHALL be preserved across window changes.
REQ-022 The design SHALL decompose into the following units; this structure is recommended, not mandatory:
- 2-to-4 window decoder with enable.
- 5-to-32 register decoder per window.
- Per-window 4:1 32-bit muxes for r8-31.
- Two 32:1 32-bit output muxes.

Reset
REQ-023 Rst=1 SHALL asynchronously clear all 72 registers to 0x00000000, independent of Clk.
REQ-024 While Rst=1, writes SHALL be blocked and r_b and r_c SHALL read 0.
REQ-025 Deasserting Rst SHALL leave the registers at 0; the first write SHALL be on the next qualifying rising Clk edge.
REQ-026 Reset asserted mid-operation SHALL override any concurrent write.

Verification
REQ-027 Reset and r0 behaviour:
- Pulse Rst with Clk idle -> r_b = r_c = 0 for every B and C in every window.
- Then write A=0, data=0xFFFFFFFF -> B=0 reads 0.
REQ-028 Global sharing:
- CWP=0, write A=5, data=0x12345678.
- CWP=1, 2 and 3 -> B=5 reads 0x12345678.
REQ-029 Overlap:
- CWP=0, write A=24, data=0xA5A5A5A5.
- CWP=1, B=8 -> 0xA5A5A5A5.
- CWP=0, B=8 -> 0 (unchanged).
REQ-030 Wrap-around:
- CWP=3, write A=31, data=0xDEADBEEF.
- CWP=0, C=15 -> 0xDEADBEEF.
REQ-031 Local privacy and write enable:
- CWP=2, write A=16, data=0x55.
- CWP=1, B=16 -> 0; CWP=6 (aliases window 2), B=16 -> 0x55.
- With RFE=0, write A=16, data=0x99 -> B=16 still reads 0x55.
REQ-032 Read-during-write and async reset:
- B=A=9 during a write of 0x77 -> r_b shows the old value before the edge and 0x77 after it.
- Assert Rst between edges -> r_b = 0 immediately.

Source files
------------

// File: rtl/windowed_regfile_4w.sv
// Purpose: 4-window register file, 32 logical x 32-bit view onto 72 physical registers (8 globals + 64-entry ring).
// Latency: reads are combinational; writes land on the rising Clk edge, with no read bypass.
// Backpressure: none; a write is accepted on every edge with RFE=1. Rst clears everything asynchronously.
module windowed_regfile_4w (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        RFE,
    input  logic [4:0]  A,
    input  logic [4:0]  B,
    input  logic [4:0]  C,
    input  logic [4:0]  CWP,
    input  logic [31:0] data,
    output logic [31:0] r_b,
    output logic [31:0] r_c
);

    localparam int NUM_PHYS = 72;

    // P0 is the hard-wired zero register, so only P1..P71 hold state.
    logic [31:0] regs [1:NUM_PHYS-1];

    logic [1:0] win;
    logic [2:0] unused_cwp_hi;
    logic [6:0] wr_idx;
    logic [6:0] rb_idx;
    logic [6:0] rc_idx;
    logic       wr_en;

    assign win           = CWP[1:0];
    assign unused_cwp_hi = CWP[4:2];

    // Globals r0-r7 map straight through. r8-r31 slide 16 registers per window
    // around a 64-entry ring starting at P8, so a window's ins are the next
    // window's outs and window 3's ins wrap onto window 0's outs.
    function automatic logic [6:0] phys_idx(input logic [4:0] r, input logic [1:0] w);
        logic [5:0] ring_off;
        ring_off = {w, 4'b0000} + ({1'b0, r} - 6'd8);
        if (r < 5'd8) begin
            phys_idx = {2'b00, r};
        end else begin
            phys_idx = 7'd8 + {1'b0, ring_off};
        end
    endfunction

    assign wr_idx = phys_idx(A, win);
    assign rb_idx = phys_idx(B, win);
    assign rc_idx = phys_idx(C, win);

    // Writes to r0 fall away here because r0 is the only name mapping to P0.
    assign wr_en = RFE && (wr_idx != 7'd0);

    // Register storage: async clear dominates, otherwise one write per edge.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 1; i < NUM_PHYS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_idx] <= data;
        end
    end

    // Combinational read ports; P0 and the reset interval read as zero.
    always_comb begin
        r_b = '0;
        r_c = '0;
        if (!Rst && (rb_idx != 7'd0)) begin
            r_b = regs[rb_idx];
        end
        if (!Rst && (rc_idx != 7'd0)) begin
            r_c = regs[rc_idx];
        end
    end

endmodule

// File: tb/tb_windowed_regfile_4w.sv
module tb_windowed_regfile_4w;

    logic        Clk;
    logic        Rst;
    logic        RFE;
    logic [4:0]  A;
    logic [4:0]  B;
    logic [4:0]  C;
    logic [4:0]  CWP;
    logic [31:0] data;
    logic [31:0] r_b;
    logic [31:0] r_c;

    int total;
    int bad;
    bit clk_run;

    // Reference model: 8 globals plus a 64-entry ring that windows slide along.
    logic [31:0] glob [8];
    logic [31:0] ring [64];

    windowed_regfile_4w dut (
        .Clk  (Clk),
        .Rst  (Rst),
        .RFE  (RFE),
        .A    (A),
        .B    (B),
        .C    (C),
        .CWP  (CWP),
        .data (data),
        .r_b  (r_b),
        .r_c  (r_c)
    );

    // Clock can be parked low so reset can be exercised with Clk idle.
    always begin
        #5;
        if (clk_run) Clk = ~Clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    function automatic void model_clear();
        for (int i = 0; i < 8; i++) glob[i] = '0;
        for (int i = 0; i < 64; i++) ring[i] = '0;
    endfunction

    function automatic logic [31:0] model_read(input int r, input int w);
        if (r == 0) return 32'h0;
        if (r < 8) return glob[r];
        return ring[(16 * w + r - 8) % 64];
    endfunction

    function automatic void model_write(input int r, input int w, input logic [31:0] d);
        if (r == 0) return;
        if (r < 8) glob[r] = d;
        else ring[(16 * w + r - 8) % 64] = d;
    endfunction

    // One clocked write; model follows the DUT only if the write qualifies.
    task automatic do_write(input logic [4:0] a, input logic [31:0] d,
                            input logic [4:0] cwp, input logic en);
        @(negedge Clk);
        A = a; data = d; CWP = cwp; RFE = en;
        @(posedge Clk);
        if (en && !Rst) model_write(int'(a), int'(cwp[1:0]), d);
        #1;
        RFE = 1'b0;
    endtask

    task automatic set_read(input logic [4:0] cwp, input logic [4:0] b, input logic [4:0] c);
        CWP = cwp; B = b; C = c;
        #1;
    endtask

    task automatic test_reset();
        clk_run = 1'b0;
        Clk = 1'b0;
        #2 Rst = 1'b1;
        #3 Rst = 1'b0;
        #1;
        model_clear();
        for (int w = 0; w < 4; w++) begin
            for (int r = 0; r < 32; r++) begin
                set_read(5'(w), 5'(r), 5'(31 - r));
                total++;
                if (r_b !== 32'h0) begin
                    bad++;
                    $display("FAIL reset_rb w=%0d B=%0d got=%h exp=0", w, r, r_b);
                end
                total++;
                if (r_c !== 32'h0) begin
                    bad++;
                    $display("FAIL reset_rc w=%0d C=%0d got=%h exp=0", w, 31 - r, r_c);
                end
            end
        end
        clk_run = 1'b1;
    endtask

    task automatic test_r0();
        do_write(5'd0, 32'hFFFF_FFFF, 5'd0, 1'b1);
        set_read(5'd0, 5'd0, 5'd0);
        total++;
        if (r_b !== 32'h0) begin
            bad++;
            $display("FAIL r0_write got=%h exp=0", r_b);
        end
    endtask

    task automatic test_globals();
        do_write(5'd5, 32'h1234_5678, 5'd0, 1'b1);
        for (int w = 1; w < 4; w++) begin
            set_read(5'(w), 5'd5, 5'd5);
            total++;
            if (r_b !== 32'h1234_5678) begin
                bad++;
                $display("FAIL global_share w=%0d got=%h exp=12345678", w, r_b);
            end
        end
    endtask

    task automatic test_overlap();
        do_write(5'd24, 32'hA5A5_A5A5, 5'd0, 1'b1);
        set_read(5'd1, 5'd8, 5'd0);
        total++;
        if (r_b !== 32'hA5A5_A5A5) begin
            bad++;
            $display("FAIL overlap_w1_r8 got=%h exp=a5a5a5a5", r_b);
        end
        set_read(5'd0, 5'd8, 5'd0);
        total++;
        if (r_b !== 32'h0) begin
            bad++;
            $display("FAIL overlap_w0_r8 got=%h exp=0", r_b);
        end
    endtask

    task automatic test_wrap();
        do_write(5'd31, 32'hDEAD_BEEF, 5'd3, 1'b1);
        set_read(5'd0, 5'd0, 5'd15);
        total++;
        if (r_c !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL wrap_w0_r15 got=%h exp=deadbeef", r_c);
        end
    endtask

    task automatic test_local_and_enable();
        do_write(5'd16, 32'h55, 5'd2, 1'b1);
        set_read(5'd1, 5'd16, 5'd0);
        total++;
        if (r_b !== 32'h0) begin
            bad++;
            $display("FAIL local_private_w1 got=%h exp=0", r_b);
        end
        set_read(5'd6, 5'd16, 5'd0);
        total++;
        if (r_b !== 32'h55) begin
            bad++;
            $display("FAIL local_cwp6_alias got=%h exp=55", r_b);
        end
        do_write(5'd16, 32'h99, 5'd2, 1'b0);
        set_read(5'd2, 5'd16, 5'd0);
        total++;
        if (r_b !== 32'h55) begin
            bad++;
            $display("FAIL rfe_low_hold got=%h exp=55", r_b);
        end
    endtask

    task automatic test_rdw_and_async_reset();
        do_write(5'd9, 32'h11, 5'd1, 1'b1);
        @(negedge Clk);
        CWP = 5'd1; A = 5'd9; B = 5'd9; C = 5'd5; data = 32'h77; RFE = 1'b1;
        #1;
        total++;
        if (r_b !== 32'h11) begin
            bad++;
            $display("FAIL rdw_before_edge got=%h exp=11", r_b);
        end
        @(posedge Clk);
        model_write(9, 1, 32'h77);
        #1;
        RFE = 1'b0;
        total++;
        if (r_b !== 32'h77) begin
            bad++;
            $display("FAIL rdw_after_edge got=%h exp=77", r_b);
        end
        // Reset between edges, held across an edge that carries a write.
        #1 Rst = 1'b1;
        #1;
        total++;
        if (r_b !== 32'h0) begin
            bad++;
            $display("FAIL async_reset_rb got=%h exp=0", r_b);
        end
        total++;
        if (r_c !== 32'h0) begin
            bad++;
            $display("FAIL async_reset_rc got=%h exp=0", r_c);
        end
        model_clear();
        @(negedge Clk);
        A = 5'd10; data = 32'hABC; RFE = 1'b1;
        @(posedge Clk);
        #1;
        RFE = 1'b0;
        Rst = 1'b0;
        set_read(5'd1, 5'd10, 5'd9);
        total++;
        if (r_b !== 32'h0) begin
            bad++;
            $display("FAIL reset_blocks_write got=%h exp=0", r_b);
        end
        total++;
        if (r_c !== 32'h0) begin
            bad++;
            $display("FAIL reset_cleared_r9 got=%h exp=0", r_c);
        end
    endtask

    task automatic test_random();
        logic [31:0] eb;
        logic [31:0] ec;
        for (int n = 0; n < 400; n++) begin
            @(negedge Clk);
            A    = 5'($urandom_range(0, 31));
            B    = 5'($urandom_range(0, 31));
            C    = ($urandom_range(0, 7) == 0) ? B : 5'($urandom_range(0, 31));
            CWP  = 5'($urandom_range(0, 31));
            data = $urandom;
            RFE  = ($urandom_range(0, 3) != 0);
            #1;
            eb = model_read(int'(B), int'(CWP[1:0]));
            ec = model_read(int'(C), int'(CWP[1:0]));
            total++;
            if (r_b !== eb) begin
                bad++;
                $display("FAIL rand_rb n=%0d cwp=%0d B=%0d got=%h exp=%h", n, CWP, B, r_b, eb);
            end
            total++;
            if (r_c !== ec) begin
                bad++;
                $display("FAIL rand_rc n=%0d cwp=%0d C=%0d got=%h exp=%h", n, CWP, C, r_c, ec);
            end
            @(posedge Clk);
            if (RFE) model_write(int'(A), int'(CWP[1:0]), data);
        end
        #1;
        RFE = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_v;
        // Consecutive writes hopping windows, then sweep every logical view.
        for (int n = 0; n < 16; n++) begin
            do_write(5'($urandom_range(1, 31)), $urandom, 5'($urandom_range(0, 31)), 1'b1);
        end
        for (int w = 0; w < 4; w++) begin
            for (int r = 0; r < 32; r++) begin
                set_read(5'(w), 5'(r), 5'(r));
                exp_v = model_read(r, w);
                total++;
                if (r_b !== exp_v || r_c !== r_b) begin
                    bad++;
                    $display("FAIL b2b_sweep w=%0d r=%0d got_b=%h got_c=%h exp=%h", w, r, r_b, r_c, exp_v);
                end
            end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        clk_run = 1'b0;
        Clk = 1'b0;
        Rst = 1'b0;
        RFE = 1'b0;
        A = '0; B = '0; C = '0; CWP = '0; data = '0;
        model_clear();

        test_reset();
        test_r0();
        test_globals();
        test_overlap();
        test_wrap();
        test_local_and_enable();
        test_rdw_and_async_reset();
        test_random();
        test_back_to_back();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
